// File: rtl/drive_sequencer_pkg.sv
// Shared types for the line-follower run-mode controller.
// Build option: DRIVE_SEQ_DEBOUNCE_EN enables sensor debounce.
package drive_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    FOLLOW = 3'd2,
    SEARCH = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } side_t;

  localparam int DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/drive_sequencer_if.sv
// Operator, sensor and motor-command bundle of the drive sequencer.
// The master drives commands and sensors; the slave is the sequencer.
interface drive_sequencer_if;

  logic       start;
  logic       stop;
  logic [1:0] ir_sensor_data;
  logic [7:0] duty_left;
  logic [7:0] duty_right;
  logic [2:0] run_state;
  logic       fault;

  modport master (
    output start, stop, ir_sensor_data,
    input  duty_left, duty_right, run_state, fault
  );

  modport slave (
    input  start, stop, ir_sensor_data,
    output duty_left, duty_right, run_state, fault
  );

endinterface

// File: rtl/duty_slew.sv
// Slew-limited duty register: steps toward target on each tick,
// never overshoots, and drops straight to zero on force_zero.
module duty_slew #(
  parameter int STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] target,
  input  logic       tick,
  input  logic       force_zero,
  output logic [7:0] duty
);

  localparam logic [7:0] S = 8'(STEP);

  logic [7:0] duty_n;

  always_comb begin
    duty_n = duty;
    if (target > duty) begin
      duty_n = (target - duty > S) ? duty + S : target;
    end else if (target < duty) begin
      duty_n = (duty - target > S) ? duty - S : target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty <= '0;
    end else if (force_zero) begin
      duty <= '0;
    end else if (tick) begin
      duty <= duty_n;
    end
  end

endmodule

// File: rtl/drive_sequencer.sv
// Run-mode controller: idle, soft start, follow, search, fault halt.
// Build option: DRIVE_SEQ_DEBOUNCE_EN enables sensor debounce.
module drive_sequencer
  import drive_pkg::*;
#(
  parameter int CRUISE_DUTY  = 200,
  parameter int TURN_DUTY    = 80,
  parameter int SEARCH_DUTY  = 120,
  parameter int RAMP_STEP    = 4,
  parameter int RAMP_DIV     = 1000,
  parameter int LOST_TIMEOUT = 50000
) (
  input logic              clk,
  input logic              reset,
  drive_sequencer_if.slave bus
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int TW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [7:0] CR = 8'(CRUISE_DUTY);
  localparam logic [7:0] TU = 8'(TURN_DUTY);
  localparam logic [7:0] SE = 8'(SEARCH_DUTY);

  logic [1:0]    ir_s1, ir_s2, ir_dec;
  state_t        state, state_n;
  side_t         side, side_n;
  logic          flt, flt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [PW-1:0] pre;
  logic          tick, force_zero;
  logic [7:0]    tgt_l, tgt_r, duty_l, duty_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_s1 <= '0;
      ir_s2 <= '0;
    end else begin
      ir_s1 <= bus.ir_sensor_data;
      ir_s2 <= ir_s1;
    end
  end

`ifdef DRIVE_SEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0]    cand, acc;
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand   <= '0;
      acc    <= '0;
      db_cnt <= '0;
    end else if (ir_s2 != cand) begin
      cand   <= ir_s2;
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      acc <= cand;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign ir_dec = acc;
`else
  assign ir_dec = ir_s2;
`endif

  assign tick = (pre == PW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  end

  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    unique case (state)
      RAMP: begin
        tgt_l = CR;
        tgt_r = CR;
      end
      FOLLOW: begin
        tgt_l = (ir_dec == 2'b10) ? TU : CR;
        tgt_r = (ir_dec == 2'b01) ? TU : CR;
      end
      SEARCH: begin
        tgt_l = (side == LEFT) ? 8'd0 : SE;
        tgt_r = (side == LEFT) ? SE : 8'd0;
      end
      default: ;
    endcase
  end

  // Stop outranks start, so a simultaneous pair lands in IDLE.
  always_comb begin
    state_n    = state;
    side_n     = side;
    flt_n      = flt;
    force_zero = 1'b0;
    if (state == FOLLOW && ir_dec == 2'b10) side_n = LEFT;
    if (state == FOLLOW && ir_dec == 2'b01) side_n = RIGHT;
    if (bus.stop) begin
      state_n    = IDLE;
      force_zero = 1'b1;
    end else if (bus.start && (state == IDLE || state == HALT)) begin
      state_n = RAMP;
      flt_n   = 1'b0;
    end else if (state == RAMP && duty_l == CR && duty_r == CR) begin
      state_n = FOLLOW;
    end else if (state == FOLLOW && ir_dec == 2'b00) begin
      state_n = SEARCH;
    end else if (state == SEARCH && ir_dec != 2'b00) begin
      state_n = FOLLOW;
    end else if (state == SEARCH && tmr == TW'(LOST_TIMEOUT - 1)) begin
      state_n    = HALT;
      flt_n      = 1'b1;
      force_zero = 1'b1;
    end
    tmr_n = '0;
    if (state == SEARCH && state_n == SEARCH) tmr_n = tmr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      side  <= LEFT;
      flt   <= 1'b0;
      tmr   <= '0;
    end else begin
      state <= state_n;
      side  <= side_n;
      flt   <= flt_n;
      tmr   <= tmr_n;
    end
  end

  duty_slew #(.STEP(RAMP_STEP)) u_left (
    .clk        (clk),
    .reset      (reset),
    .target     (tgt_l),
    .tick       (tick),
    .force_zero (force_zero),
    .duty       (duty_l)
  );

  duty_slew #(.STEP(RAMP_STEP)) u_right (
    .clk        (clk),
    .reset      (reset),
    .target     (tgt_r),
    .tick       (tick),
    .force_zero (force_zero),
    .duty       (duty_r)
  );

  assign bus.duty_left  = duty_l;
  assign bus.duty_right = duty_r;
  assign bus.run_state  = state;
  assign bus.fault      = flt;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed plus random bench for drive_sequencer against a
// cycle-level reference model of the run-mode rules.
module tb_drive_sequencer;

  localparam int CRUISE = 200;
  localparam int TURN   = 80;
  localparam int SRCH   = 120;
  localparam int STEP   = 50;
  localparam int DIV    = 4;
  localparam int LOST   = 100;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  drive_sequencer_if bus ();

  drive_sequencer #(
    .RAMP_STEP    (STEP),
    .RAMP_DIV     (DIV),
    .LOST_TIMEOUT (LOST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model; states numbered 0 idle .. 4 halt
  int m_st, m_l, m_r, m_side, m_flt, m_pre, m_lost;
  logic [1:0] m_s1, m_s2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int slew(input int d, input int t);
    if (d < t) return (t - d > STEP) ? d + STEP : t;
    return (d - t > STEP) ? d - STEP : t;
  endfunction

  task automatic model_edge();
    logic [1:0] dec;
    int tl, tr, nst, nf, fz;
    bit tk;
    if (reset) begin
      m_st = 0; m_l = 0; m_r = 0; m_side = 0;
      m_flt = 0; m_pre = 0; m_lost = 0;
      m_s1 = 0; m_s2 = 0;
      return;
    end
    dec = m_s2;
    tk  = (m_pre == DIV - 1);
    tl = 0; tr = 0;
    case (m_st)
      1: begin tl = CRUISE; tr = CRUISE; end
      2: begin
        tl = (dec == 2'b10) ? TURN : CRUISE;
        tr = (dec == 2'b01) ? TURN : CRUISE;
      end
      3: begin
        tl = m_side ? SRCH : 0;
        tr = m_side ? 0 : SRCH;
      end
      default: ;
    endcase
    nst = m_st; nf = m_flt; fz = 0;
    if (bus.stop) begin
      nst = 0; fz = 1;
    end else if (bus.start && (m_st == 0 || m_st == 4)) begin
      nst = 1; nf = 0;
    end else if (m_st == 1 && m_l == CRUISE && m_r == CRUISE) begin
      nst = 2;
    end else if (m_st == 2 && dec == 0) begin
      nst = 3;
    end else if (m_st == 3 && dec != 0) begin
      nst = 2;
    end else if (m_st == 3 && m_lost == LOST - 1) begin
      nst = 4; nf = 1; fz = 1;
    end
    if (m_st == 2 && dec == 2'b10) m_side = 0;
    if (m_st == 2 && dec == 2'b01) m_side = 1;
    m_lost = (m_st == 3 && nst == 3) ? m_lost + 1 : 0;
    m_l = fz ? 0 : (tk ? slew(m_l, tl) : m_l);
    m_r = fz ? 0 : (tk ? slew(m_r, tr) : m_r);
    m_st  = nst;
    m_flt = nf;
    m_pre = tk ? 0 : m_pre + 1;
    m_s2 = m_s1;
    m_s1 = bus.ir_sensor_data;
  endtask

  task automatic cyc(input logic st, input logic sp,
                     input logic [1:0] ir);
    bus.start = st;
    bus.stop  = sp;
    bus.ir_sensor_data = ir;
    @(posedge clk);
    model_edge();
    #1;
`ifndef DRIVE_SEQ_DEBOUNCE_EN
    chk("duty_left", bus.duty_left, m_l);
    chk("duty_right", bus.duty_right, m_r);
    chk("run_state", bus.run_state, m_st);
    chk("fault", bus.fault, m_flt);
`endif
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    int seen[$];
    int prev, n;
    logic [1:0] ir;
    bus.start = 0;
    bus.stop  = 0;
    bus.ir_sensor_data = 2'b11;

    reset = 1'b1;
    cyc(0, 0, 2'b11);
    cyc(0, 0, 2'b11);
    reset = 1'b0;
    chk("rst_state", bus.run_state, 0);
    chk("rst_duty", {bus.duty_left, bus.duty_right}, 0);
    chk("rst_fault", bus.fault, 0);

    cyc(0, 0, 2'b11);
    cyc(1, 0, 2'b11);
    prev = 0;
    for (int i = 0; i < 40 && bus.run_state !== 3'd2; i++) begin
      cyc(0, 0, 2'b11);
      if (bus.duty_left != prev) seen.push_back(int'(bus.duty_left));
      prev = int'(bus.duty_left);
    end
    chk("ramp_steps", seen.size(), 4);
    for (int i = 0; i < seen.size() && i < 4; i++)
      chk("ramp_val", seen[i], 50 * (i + 1));
    chk("ramp_follow", bus.run_state, 2);

    for (int i = 0; i < 20; i++) cyc(0, 0, 2'b10);
    chk("turn_left", bus.duty_left, TURN);
    chk("turn_right", bus.duty_right, CRUISE);

    for (int i = 0; i < 20; i++) cyc(0, 0, 2'b01);
    for (int i = 0; i < 60; i++) cyc(0, 0, 2'b00);
    chk("search_state", bus.run_state, 3);
    chk("search_left", bus.duty_left, SRCH);
    chk("search_right", bus.duty_right, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 2'b01);
    chk("refound", bus.run_state, 2);
    chk("refound_flt", bus.fault, 0);

    n = 0;
    for (int i = 0; i < 130 && bus.run_state !== 3'd4; i++) begin
      cyc(0, 0, 2'b00);
      if (bus.run_state == 3'd3) n++;
    end
    chk("search_len", n, LOST);
    chk("halt_state", bus.run_state, 4);
    chk("halt_fault", bus.fault, 1);
    chk("halt_duty", {bus.duty_left, bus.duty_right}, 0);
    cyc(1, 0, 2'b11);
    chk("restart", bus.run_state, 1);
    chk("restart_flt", bus.fault, 0);

    for (int i = 0; i < 40 && bus.run_state !== 3'd2; i++)
      cyc(0, 0, 2'b11);
`ifdef DRIVE_SEQ_DEBOUNCE_EN
    for (int i = 0; i < 30; i++) cyc(0, 0, 2'b11);
    for (int i = 0; i < 10; i++) cyc(0, 0, 2'b00);
    for (int i = 0; i < 30; i++) begin
      cyc(0, 0, 2'b11);
      chk("glitch", bus.run_state, 2);
    end
`endif
    cyc(1, 1, 2'b11);
    chk("stopwin", bus.run_state, 0);
    chk("stop_duty", {bus.duty_left, bus.duty_right}, 0);

    ir = 2'b11;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) ir = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0, ir);
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
